// File: rtl/mac_fb_arbiter.sv
// mac_fb_arbiter: shares a single-port 16K x 16 framebuffer SPRAM between the
// display scanout (absolute priority, fixed 2-cycle return) and the dither
// writer (absorbed by a small FIFO, drained into idle RAM cycles).
// Optional build macro: MAC_FB_STATS_EN enables the deferred-write counter
// on stall_count; without it stall_count is tied to zero.
module mac_fb_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_16mhz,
  input  logic                              reset,
  input  logic                              rd_req,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid,
  input  logic                              wr_valid,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic                              mem_wen,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [15:0]                       stall_count
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = IDX_W + 1;

  // FIFO storage and pointers (pointers carry one extra wrap bit)
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;

  // Read return pipeline
  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0] rd_data_p2_q, rd_data_p2_d;

  // Grant / handshake decode
  logic [LVL_W-1:0]  level;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              wr_grant;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Occupancy, handshake and per-cycle RAM grant
  always_comb begin
    level      = wr_ptr_q - rd_ptr_q;
    fifo_empty = (level == '0);
    fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    wr_idx     = wr_ptr_q[IDX_W-1:0];
    rd_idx     = rd_ptr_q[IDX_W-1:0];
    // Ready depends on the registered level only: a pop in the same cycle
    // does not open a slot until the next cycle.
    wr_ready   = !fifo_full;
    push       = wr_valid && !fifo_full && !reset;
    // The scanout always wins; the FIFO head goes out only on a free cycle.
    wr_grant   = !rd_req && !fifo_empty && !reset;
    mem_wen    = wr_grant;
    mem_addr   = rd_req ? rd_addr : fifo_addr_q[rd_idx];
    mem_wdata  = fifo_data_q[rd_idx];
    fifo_level = level;
  end

  // Next-state for pointers, FIFO contents and the read return pipeline
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q + LVL_W'(push);
    rd_ptr_d    = rd_ptr_q + LVL_W'(wr_grant);
    if (push) begin
      fifo_addr_d[wr_idx] = wr_addr;
      fifo_data_d[wr_idx] = wr_data;
    end
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    vld_p1_d     = rd_req;
    vld_p2_d     = vld_p1_q;
    rd_data_p2_d = vld_p1_q ? mem_rdata : rd_data_p2_q;
    if (reset) begin
      vld_p1_d     = 1'b0;
      vld_p2_d     = 1'b0;
      rd_data_p2_d = '0;
    end
  end

  // FIFO payload registers; contents are don't-care while the slot is empty
  always_ff @(posedge clk_16mhz) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // Control state: pointers and read pipeline (reset clears in-flight reads)
  always_ff @(posedge clk_16mhz) begin
    wr_ptr_q     <= wr_ptr_d;
    rd_ptr_q     <= rd_ptr_d;
    // stage 0 -> 1: request accepted, RAM is reading this cycle
    vld_p1_q     <= vld_p1_d;
    // stage 1 -> 2: RAM data captured, return presented
    vld_p2_q     <= vld_p2_d;
    rd_data_p2_q <= rd_data_p2_d;
  end

  assign rd_valid = vld_p2_q;
  assign rd_data  = rd_data_p2_q;

`ifdef MAC_FB_STATS_EN
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles where a queued write waits behind a scanout read
  always_comb begin
    stall_d = stall_q;
    if (rd_req && !fifo_empty) stall_d = sat_inc16(stall_q);
    if (reset) stall_d = '0;
  end

  // Deferred-write counter register
  always_ff @(posedge clk_16mhz) begin
    stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mac_fb_arbiter.sv
// Self-checking bench for mac_fb_arbiter: directed table, hand-written
// corner-case sequences and a randomized run, all compared against a
// transaction-level reference (queue of pending writes, list of pending
// read returns, shadow copy of RAM contents).
module tb_mac_fb_arbiter;

  localparam int DEPTH = 4;
`ifdef MAC_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_16mhz;
  logic        reset;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [2:0]  fifo_level;
  logic [13:0] mem_addr;
  logic        mem_wen;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] stall_count;

  mac_fb_arbiter #(.ADDR_W(14), .DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_16mhz  (clk_16mhz),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_level (fifo_level),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_count(stall_count)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  // SPRAM model with a backdoor load port
  bit [15:0]   ram [16384];
  logic        bd_we;
  logic [13:0] bd_addr;
  logic [15:0] bd_data;
  always @(posedge clk_16mhz) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wen) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  typedef struct { logic [13:0] addr; logic [15:0] data; } wentry_t;
  typedef struct { int due; logic [15:0] data; } ret_t;
  wentry_t     q[$];
  ret_t        retq[$];
  bit [15:0]   ref_mem [16384];
  logic [15:0] exp_rd_data;
  logic [15:0] exp_stall;
  logic        exp_rv;
  logic        exp_wen;
  int          cyc;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic rq, input logic [13:0] ra,
                       input logic wv, input logic [13:0] wa, input logic [15:0] wd);
    reset    = rs;
    rd_req   = rq;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
  endtask

  // Compare all outputs against the reference in mid-cycle
  task automatic settle();
    @(negedge clk_16mhz);
    exp_rv = 1'b0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      exp_rv      = 1'b1;
      exp_rd_data = retq[0].data;
      void'(retq.pop_front());
    end
    exp_wen = !reset && !rd_req && (q.size() != 0);
    chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
    chk("stall_count", 32'(stall_count), 32'(exp_stall));
    if (rd_req) chk("mem_addr_rd", 32'(mem_addr), 32'(rd_addr));
    if (exp_wen) begin
      chk("mem_addr_wr", 32'(mem_addr), 32'(q[0].addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(q[0].data));
    end
  endtask

  // Apply the clock edge to the reference, then to the DUT
  task automatic advance();
    int sz;
    sz = q.size();
    if (reset) begin
      q.delete();
      retq.delete();
      exp_rd_data = '0;
      exp_stall   = '0;
    end else begin
      if (rd_req) retq.push_back('{due: cyc + 2, data: ref_mem[rd_addr]});
      if (STATS && rd_req && sz != 0 && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (!rd_req && sz != 0) begin
        ref_mem[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
      if (wr_valid && sz != DEPTH) q.push_back('{addr: wr_addr, data: wr_data});
    end
    @(posedge clk_16mhz);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic        rq;  logic [13:0] ra;
    logic        wv;  logic [13:0] wa; logic [15:0] wd;
    logic        e_wen; logic [13:0] e_addr; logic [15:0] e_wdata;
    logic        e_ready; logic [2:0] e_lvl; logic e_rv; logic [15:0] e_rdata;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int acc;
    tbl[0]  = '{1'b0, 14'h000, 1'b1, 14'h000, 16'hA000, 1'b0, 14'h000, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 14'h000, 1'b1, 14'h001, 16'hA001, 1'b1, 14'h000, 16'hA000, 1'b1, 3'd1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 14'h000, 1'b1, 14'h002, 16'hA002, 1'b1, 14'h001, 16'hA001, 1'b1, 3'd1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 14'h000, 1'b1, 14'h003, 16'hA003, 1'b1, 14'h002, 16'hA002, 1'b1, 3'd1, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 14'h000, 1'b0, 14'h000, 16'h0000, 1'b1, 14'h003, 16'hA003, 1'b1, 3'd1, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 14'h000, 1'b0, 14'h000, 16'h0000, 1'b0, 14'h000, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 14'h200, 1'b1, 14'h010, 16'hB010, 1'b0, 14'h200, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 14'h201, 1'b1, 14'h011, 16'hB011, 1'b0, 14'h201, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 14'h123, 1'b0, 14'h000, 16'h0000, 1'b0, 14'h123, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h0000};
    tbl[9]  = '{1'b0, 14'h000, 1'b0, 14'h000, 16'h0000, 1'b1, 14'h010, 16'hB010, 1'b1, 3'd2, 1'b1, 16'h0000};
    tbl[10] = '{1'b0, 14'h000, 1'b0, 14'h000, 16'h0000, 1'b1, 14'h011, 16'hB011, 1'b1, 3'd1, 1'b1, 16'hBEEF};
    tbl[11] = '{1'b0, 14'h000, 1'b0, 14'h000, 16'h0000, 1'b0, 14'h000, 16'h0000, 1'b1, 3'd0, 1'b0, 16'hBEEF};

    checks = 0; failures = 0; cyc = 0;
    exp_rd_data = '0; exp_stall = '0;
    clk_16mhz = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
    ref_mem[14'h123] = 16'hBEEF;
    bd_we = 1'b1; bd_addr = 14'h123; bd_data = 16'hBEEF;
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    @(posedge clk_16mhz);
    #1;
    bd_we = 1'b0;

    // Reset held for 3 cycles with random inputs
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)),
            1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)), 16'($urandom));
      settle();
      chk("rst_mem_wen", 32'(mem_wen), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      advance();
    end
    drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    settle();
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_rd_data", 32'(rd_data), 32'd0);
    advance();

    // Directed table: write burst then read priority over two queued writes
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].rq, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      settle();
      chk("tbl_wen", 32'(mem_wen), 32'(tbl[i].e_wen));
      if (tbl[i].e_wen || tbl[i].rq) chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_wen) chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].e_wdata));
      chk("tbl_ready", 32'(wr_ready), 32'(tbl[i].e_ready));
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk("tbl_rv", 32'(rd_valid), 32'(tbl[i].e_rv));
      chk("tbl_rdata", 32'(rd_data), 32'(tbl[i].e_rdata));
      advance();
    end

    // Full FIFO under continuous reads, then drain in order
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 14'(32'h300 + k), 1'b1, 14'(32'h40 + acc), 16'(32'hC000 + acc));
      settle();
      if (wr_ready) acc++;
      advance();
    end
    chk("full_accepted", 32'(acc), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
      settle();
      chk("drain_wen", 32'(mem_wen), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h40 + 32'(k));
      chk("drain_wdata", 32'(mem_wdata), 32'hC000 + 32'(k));
      chk("drain_ready", 32'(wr_ready), 32'(k != 0));
      advance();
    end

    // Reset mid-operation: 3 queued entries plus a read in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 14'(32'h400 + k), 1'b1, 14'(32'h50 + k), 16'(32'hE000 + k));
      settle();
      advance();
    end
    drive(1'b0, 1'b1, 14'h410, 1'b0, 14'h0, 16'h0);
    settle();
    advance();
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    settle();
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
      settle();
      chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
      chk("midrst_wen", 32'(mem_wen), 32'd0);
      chk("midrst_level", 32'(fifo_level), 32'd0);
      advance();
    end

    // Stats: one deferred cycle while filling to 2, then 3 more read cycles
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    settle();
    advance();
    drive(1'b0, 1'b1, 14'h500, 1'b1, 14'h060, 16'hD000);
    settle();
    advance();
    drive(1'b0, 1'b1, 14'h501, 1'b1, 14'h061, 16'hD001);
    settle();
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 14'(32'h502 + k), 1'b0, 14'h0, 16'h0);
      settle();
      advance();
    end
    drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    settle();
    chk("stats_count", 32'(stall_count), STATS ? 32'd4 : 32'd0);
    advance();

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) == 0),
            14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
            14'($urandom_range(0, 16383)), 16'($urandom));
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
